// File: rtl/rf_sched_pkg.sv
// Shared widths, types and helpers for the register-file write scheduler.
package rf_sched_pkg;

    localparam int unsigned WORD_LENGTH = 32;
    localparam int unsigned ADDR_LENGTH = 5;
    localparam int unsigned MAX_REQ     = 32;
    localparam int unsigned IDX_W       = $clog2(MAX_REQ);

    typedef logic [WORD_LENGTH-1:0] rf_word_t;
    typedef logic [ADDR_LENGTH-1:0] rf_addr_t;

    // Index of the set bit in a one-hot vector; 0 when no bit is set.
    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (onehot[IDX_W'(i)]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rf_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, search starts at ptr.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[PTR_W'(idx)]) begin
                gnt[PTR_W'(idx)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Round-robin scheduler for the single register-file write port with a busy scoreboard.
// Optional RF_SCHED_BYPASS_EN adds two combinational forwarding read ports.
module rf_write_scheduler #(
    parameter int unsigned WORD_LENGTH = rf_sched_pkg::WORD_LENGTH,
    parameter int unsigned ADDR_LENGTH = rf_sched_pkg::ADDR_LENGTH,
    parameter int unsigned NUM_REQ     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_LENGTH-1:0] req_addr,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
    input  logic                           rsv_valid,
    input  logic [ADDR_LENGTH-1:0]         rsv_addr,
    output logic                           rsv_ready,
    output logic [2**ADDR_LENGTH-1:0]      busy,
    output logic                           rf_we,
    output logic [ADDR_LENGTH-1:0]         rf_wa,
    output logic [WORD_LENGTH-1:0]         rf_wd
`ifdef RF_SCHED_BYPASS_EN
   ,input  logic [ADDR_LENGTH-1:0]         byp_ra1,
    input  logic [ADDR_LENGTH-1:0]         byp_ra2,
    output logic                           byp_hit1,
    output logic                           byp_hit2,
    output logic [WORD_LENGTH-1:0]         byp_rd1,
    output logic [WORD_LENGTH-1:0]         byp_rd2
`endif
);

    import rf_sched_pkg::*;

    localparam int unsigned PTR_W    = $clog2(NUM_REQ);
    localparam int unsigned NUM_REGS = 2**ADDR_LENGTH;

    logic [NUM_REQ-1:0]     gnt;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W-1:0]       ptr_next;
    logic                   xfer;
    logic [ADDR_LENGTH-1:0] sel_addr;
    logic [WORD_LENGTH-1:0] sel_data;
    logic [NUM_REGS-1:0]    busy_next;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign gnt_idx   = PTR_W'(onehot_to_idx(MAX_REQ'(gnt)));
    assign sel_addr  = req_addr[gnt_idx*ADDR_LENGTH +: ADDR_LENGTH];
    assign sel_data  = req_data[gnt_idx*WORD_LENGTH +: WORD_LENGTH];
    assign ptr_next  = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);

    // One outstanding producer per register; busy[0] is never set so x0 always accepts.
    assign rsv_ready = !busy[rsv_addr];

    // Clear on commit first, then set, so a same-edge reservation wins.
    always_comb begin
        busy_next = busy;
        if (rf_we) busy_next[rf_wa] = 1'b0;
        if (rsv_valid && rsv_ready) busy_next[rsv_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Registered write stage, round-robin pointer and scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            rr_ptr <= '0;
            busy   <= '0;
        end else begin
            rf_we <= xfer && (sel_addr != '0);
            if (xfer) begin
                rf_wa  <= sel_addr;
                rf_wd  <= sel_data;
                rr_ptr <= ptr_next;
            end
            busy <= busy_next;
        end
    end

`ifdef RF_SCHED_BYPASS_EN
    // Forward the write being committed this cycle.
    assign byp_hit1 = rf_we && (rf_wa == byp_ra1) && (byp_ra1 != '0);
    assign byp_hit2 = rf_we && (rf_wa == byp_ra2) && (byp_ra2 != '0);
    assign byp_rd1  = byp_hit1 ? rf_wd : '0;
    assign byp_rd2  = byp_hit2 ? rf_wd : '0;
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: directed scenarios plus a randomized model run.
module tb_rf_write_scheduler;

    localparam int unsigned WL    = 32;
    localparam int unsigned AL    = 5;
    localparam int unsigned NR    = 2;
    localparam int unsigned NREGS = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AL-1:0]  req_addr;
    logic [NR*WL-1:0]  req_data;
    logic              rsv_valid;
    logic [AL-1:0]     rsv_addr;
    logic              rsv_ready;
    logic [NREGS-1:0]  busy;
    logic              rf_we;
    logic [AL-1:0]     rf_wa;
    logic [WL-1:0]     rf_wd;
`ifdef RF_SCHED_BYPASS_EN
    logic [AL-1:0]     byp_ra1, byp_ra2;
    logic              byp_hit1, byp_hit2;
    logic [WL-1:0]     byp_rd1, byp_rd2;
`endif

    int checks = 0;
    int errors = 0;

    rf_write_scheduler #(.WORD_LENGTH(WL), .ADDR_LENGTH(AL), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .busy      (busy),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd)
`ifdef RF_SCHED_BYPASS_EN
       ,.byp_ra1   (byp_ra1),
        .byp_ra2   (byp_ra2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_rd1   (byp_rd1),
        .byp_rd2   (byp_rd2)
`endif
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AL-1:0] a, input logic [WL-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AL +: AL] = a;
        req_data[i*WL +: WL] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
`ifdef RF_SCHED_BYPASS_EN
        byp_ra1 = '0;
        byp_ra2 = '0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        next_cycle();
        settle();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", rf_we); end
        checks++; if (rf_wa !== '0) begin errors++; $display("FAIL reset_wa: got %0d exp 0", rf_wa); end
        checks++; if (rf_wd !== '0) begin errors++; $display("FAIL reset_wd: got %h exp 0", rf_wd); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %h exp 0", busy); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", req_ready); end
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL reset_rsv_ready: got %b exp 1", rsv_ready); end
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        set_req(0, 1'b1, 5'd3, $urandom);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd3;
        settle();
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_grant: got %b exp 01", req_ready); end
        next_cycle();
        idle();
        settle();
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3) begin errors++; $display("FAIL mid_staged: got we=%b wa=%0d exp we=1 wa=3", rf_we, rf_wa); end
        checks++; if (busy !== 32'h8) begin errors++; $display("FAIL mid_busy_pre: got %h exp 8", busy); end
        reset = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_reset_we: got %b exp 0", rf_we); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL mid_reset_busy: got %h exp 0", busy); end
        next_cycle();
        reset = 1'b0;
        set_req(0, 1'b1, 5'd1, $urandom);
        set_req(1, 1'b1, 5'd2, $urandom);
        settle();
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_ptr_zero: got %b exp 01", req_ready); end
        idle();
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [WL-1:0] dv [NR];
        logic [AL-1:0] exp_wa [4];
        logic [WL-1:0] exp_wd [4];
        logic [NR-1:0] exp_g;
        int g;
        dv[0] = $urandom;
        dv[1] = $urandom;
        set_req(0, 1'b1, 5'd3, dv[0]);
        set_req(1, 1'b1, 5'd4, dv[1]);
        for (int k = 0; k < 6; k++) begin
            settle();
            if (k < 4) begin
                g     = k % 2;
                exp_g = NR'(1) << g;
                checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant k=%0d: got %b exp %b", k, req_ready, exp_g); end
                exp_wa[k] = (g == 0) ? 5'd3 : 5'd4;
                exp_wd[k] = dv[g];
            end
            if (k > 0 && k < 5) begin
                checks++; if (rf_we !== 1'b1 || rf_wa !== exp_wa[k-1] || rf_wd !== exp_wd[k-1]) begin
                    errors++; $display("FAIL rr_write k=%0d: got we=%b wa=%0d wd=%h exp we=1 wa=%0d wd=%h", k, rf_we, rf_wa, rf_wd, exp_wa[k-1], exp_wd[k-1]);
                end
            end
            if (k == 5) begin
                checks++; if (rf_we !== 1'b0 || rf_wa !== 5'd4 || rf_wd !== exp_wd[3]) begin
                    errors++; $display("FAIL rr_hold: got we=%b wa=%0d wd=%h exp we=0 wa=4 wd=%h", rf_we, rf_wa, rf_wd, exp_wd[3]);
                end
            end
            next_cycle();
            if (k < 3) begin
                g     = k % 2;
                dv[g] = $urandom;
                set_req(g, 1'b1, (g == 0) ? 5'd3 : 5'd4, dv[g]);
            end else begin
                idle();
            end
        end
    endtask

    task automatic test_x0_write();
        set_req(0, 1'b1, 5'd0, 32'hDEADBEEF);
        settle();
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL x0_grant: got %b exp 01", req_ready); end
        next_cycle();
        idle();
        settle();
        checks++; if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL x0_stage: got we=%b wa=%0d wd=%h exp we=0 wa=0 wd=deadbeef", rf_we, rf_wa, rf_wd);
        end
        checks++; if (busy !== '0) begin errors++; $display("FAIL x0_busy: got %h exp 0", busy); end
        next_cycle();
    endtask

    task automatic test_scoreboard();
        logic [WL-1:0] d;
        d = $urandom;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd5;
        settle();
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL sb_first_rsv: got %b exp 1", rsv_ready); end
        next_cycle();
        settle();
        checks++; if (busy !== 32'h20) begin errors++; $display("FAIL sb_busy_set: got %h exp 20", busy); end
        checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL sb_waw_stall: got %b exp 0", rsv_ready); end
        next_cycle();
        rsv_addr = 5'd0;
        set_req(1, 1'b1, 5'd5, d);
        settle();
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL sb_x0_rsv: got %b exp 1", rsv_ready); end
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL sb_grant: got %b exp 10", req_ready); end
        next_cycle();
        idle();
        settle();
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== d) begin
            errors++; $display("FAIL sb_write: got we=%b wa=%0d wd=%h exp we=1 wa=5 wd=%h", rf_we, rf_wa, rf_wd, d);
        end
        checks++; if (busy !== 32'h20) begin errors++; $display("FAIL sb_busy_hold: got %h exp 20", busy); end
        next_cycle();
        settle();
        checks++; if (busy !== '0) begin errors++; $display("FAIL sb_busy_clear: got %h exp 0", busy); end
        next_cycle();
    endtask

    task automatic test_collision();
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        next_cycle();
        idle();
        set_req(0, 1'b1, 5'd7, $urandom);
        settle();
        checks++; if (busy !== 32'h80) begin errors++; $display("FAIL col_busy_set: got %h exp 80", busy); end
        next_cycle();
        idle();
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        settle();
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7) begin errors++; $display("FAIL col_write: got we=%b wa=%0d exp we=1 wa=7", rf_we, rf_wa); end
        checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL col_rsv_busy: got %b exp 0", rsv_ready); end
        next_cycle();
        idle();
        settle();
        checks++; if (busy !== '0) begin errors++; $display("FAIL col_clear: got %h exp 0", busy); end
        set_req(1, 1'b1, 5'd7, $urandom);
        next_cycle();
        idle();
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        settle();
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || busy !== '0) begin
            errors++; $display("FAIL col2_write: got we=%b wa=%0d busy=%h exp we=1 wa=7 busy=0", rf_we, rf_wa, busy);
        end
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL col2_rsv: got %b exp 1", rsv_ready); end
        next_cycle();
        idle();
        settle();
        checks++; if (busy !== 32'h80) begin errors++; $display("FAIL col2_set_wins: got %h exp 80", busy); end
        next_cycle();
    endtask

`ifdef RF_SCHED_BYPASS_EN
    task automatic test_bypass();
        set_req(0, 1'b1, 5'd9, 32'h1234);
        next_cycle();
        idle();
        byp_ra1 = 5'd9;
        byp_ra2 = 5'd0;
        settle();
        checks++; if (byp_hit1 !== 1'b1 || byp_rd1 !== 32'h1234) begin errors++; $display("FAIL byp_hit1: got hit=%b rd=%h exp hit=1 rd=1234", byp_hit1, byp_rd1); end
        checks++; if (byp_hit2 !== 1'b0 || byp_rd2 !== '0) begin errors++; $display("FAIL byp_x0: got hit=%b rd=%h exp hit=0 rd=0", byp_hit2, byp_rd2); end
        byp_ra2 = 5'd9;
        byp_ra1 = 5'd8;
        #1;
        checks++; if (byp_hit2 !== 1'b1 || byp_rd2 !== 32'h1234 || byp_hit1 !== 1'b0) begin
            errors++; $display("FAIL byp_hit2: got hit2=%b rd2=%h hit1=%b exp 1 1234 0", byp_hit2, byp_rd2, byp_hit1);
        end
        next_cycle();
        byp_ra1 = 5'd9;
        settle();
        checks++; if (byp_hit1 !== 1'b0 || byp_rd1 !== '0) begin errors++; $display("FAIL byp_idle: got hit=%b rd=%h exp hit=0 rd=0", byp_hit1, byp_rd1); end
        idle();
        next_cycle();
    endtask
`endif

    task automatic test_random();
        logic             pend  [NR];
        logic [AL-1:0]    paddr [NR];
        logic [WL-1:0]    pdata [NR];
        logic [NREGS-1:0] m_busy;
        logic             m_we;
        logic [AL-1:0]    m_wa;
        logic [WL-1:0]    m_wd;
        logic [NR-1:0]    exp_rdy;
        logic             exp_rsv;
        int               m_ptr, g;
        reset = 1'b1;
        idle();
        next_cycle();
        reset = 1'b0;
        m_busy = '0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_ptr = 0;
        for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0; end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 60) begin
                    pend[i]  = 1'b1;
                    paddr[i] = AL'($urandom_range(0, 7));
                    pdata[i] = $urandom;
                end
                set_req(i, pend[i], paddr[i], pdata[i]);
            end
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = AL'($urandom_range(0, 7));
            settle();
            g = -1;
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && pend[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
            exp_rdy = (g < 0) ? '0 : NR'(1) << g;
            exp_rsv = (rsv_addr == 0) ? 1'b1 : !m_busy[rsv_addr];
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_grant c=%0d: got %b exp %b", c, req_ready, exp_rdy); end
            checks++; if (rsv_ready !== exp_rsv) begin errors++; $display("FAIL rnd_rsv c=%0d: got %b exp %b", c, rsv_ready, exp_rsv); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy c=%0d: got %h exp %h", c, busy, m_busy); end
            checks++; if (rf_we !== m_we || rf_wa !== m_wa || rf_wd !== m_wd) begin
                errors++; $display("FAIL rnd_write c=%0d: got we=%b wa=%0d wd=%h exp we=%b wa=%0d wd=%h", c, rf_we, rf_wa, rf_wd, m_we, m_wa, m_wd);
            end
            if (m_we) m_busy[m_wa] = 1'b0;
            if (rsv_valid && exp_rsv && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
            if (g >= 0) begin
                m_we    = (paddr[g] != 0);
                m_wa    = paddr[g];
                m_wd    = pdata[g];
                m_ptr   = (g + 1) % NR;
                pend[g] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            next_cycle();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_reset_mid_burst();
        test_round_robin();
        test_x0_write();
        test_scoreboard();
        test_collision();
`ifdef RF_SCHED_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
